// File: rtl/skinny_sbox8_pini1_layer_driver.sv
// Byte-serial sequencer for one external 2-share PINI1 SKINNY sbox8 core.
// Holds core inputs and refresh mask stable for SB_LAT cycles per byte,
// consumes one fresh PRNG byte per state byte, and writes results in place.
module skinny_sbox8_pini1_layer_driver #(
  parameter int unsigned NBYTES = 16,
  parameter int unsigned SB_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_s0,
  input  logic [8*NBYTES-1:0] in_s1,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  input  logic [7:0]          rnd,
  output logic [7:0]          sb_si0,
  output logic [7:0]          sb_si1,
  output logic [7:0]          sb_r,
  input  logic [7:0]          sb_bo0,
  input  logic [7:0]          sb_bo1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_s0,
  output logic [8*NBYTES-1:0] out_s1,
  output logic                busy
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned CNT_W = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SB_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [8*NBYTES-1:0] r_s0;
  logic [8*NBYTES-1:0] r_s1;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_si0;
  logic [7:0]          r_si1;
  logic [7:0]          r_r;
  logic                w_hold_last;

  assign w_hold_last = (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    rnd_ready   = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        rnd_ready = 1'b1;
        busy      = 1'b1;
        if (rnd_valid) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (w_hold_last) w_state_nxt = (r_idx == IDX_LAST) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Share registers, byte index, hold counter and registered core inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0  <= '0;
      r_s1  <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_si0 <= '0;
      r_si1 <= '0;
      r_r   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_s0  <= in_s0;
            r_s1  <= in_s1;
            r_idx <= '0;
          end
        end
        ST_FETCH: begin
          if (rnd_valid) begin
            r_r   <= rnd;
            r_si0 <= r_s0[8*r_idx +: 8];
            r_si1 <= r_s1[8*r_idx +: 8];
            r_cnt <= '0;
          end
        end
        ST_HOLD: begin
          // Core inputs stay untouched here; only the result byte is written back.
          if (w_hold_last) begin
            r_s0[8*r_idx +: 8] <= sb_bo0;
            r_s1[8*r_idx +: 8] <= sb_bo1;
            if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_si0 <= '0;
            r_si1 <= '0;
            r_r   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sb_si0 = r_si0;
  assign sb_si1 = r_si1;
  assign sb_r   = r_r;
  assign out_s0 = r_s0;
  assign out_s1 = r_s1;

endmodule

// File: tb/tb_skinny_sbox8_pini1_layer_driver.sv
// Self-checking bench: behavioural SKINNY sbox8 core model with latency
// enforcement, randomized share/mask stimulus, and a byte-level reference.
module tb_skinny_sbox8_pini1_layer_driver;

  localparam int unsigned NB  = 16;
  localparam int unsigned LAT = 4;
  localparam int unsigned W   = 8 * NB;

  logic         clk = 1'b0;
  logic         rst, in_valid, rnd_valid, out_ready;
  logic [W-1:0] in_s0, in_s1;
  logic [7:0]   rnd, sb_bo0, sb_bo1;
  logic         in_ready, rnd_ready, out_valid, busy;
  logic [7:0]   sb_si0, sb_si1, sb_r;
  logic [W-1:0] out_s0, out_s1;

  int n_total = 0;
  int n_pass  = 0;

  skinny_sbox8_pini1_layer_driver #(.NBYTES(NB), .SB_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_s0(in_s0), .in_s1(in_s1),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .sb_si0(sb_si0), .sb_si1(sb_si1), .sb_r(sb_r),
    .sb_bo0(sb_bo0), .sb_bo1(sb_bo1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s0(out_s0), .out_s1(out_s1), .busy(busy)
  );

  always #5 clk = ~clk;

  // SKINNY 8-bit S-box, computed from its mix/permute round structure
  function automatic logic [7:0] sbox8(input logic [7:0] a);
    logic [7:0] x;
    x = a;
    for (int i = 0; i < 4; i++) begin
      x = ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
      if (i < 3)
        x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
            ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    end
    x = (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    return x;
  endfunction

  // Reference: share 0 = S(x)^r, share 1 = r for each byte
  function automatic logic [W-1:0] ref_sh0(input logic [W-1:0] s0, input logic [W-1:0] s1,
                                           input logic [W-1:0] r);
    logic [W-1:0] o;
    for (int i = 0; i < NB; i++) o[8*i +: 8] = sbox8(s0[8*i +: 8] ^ s1[8*i +: 8]) ^ r[8*i +: 8];
    return o;
  endfunction

  function automatic logic [W-1:0] rep_byte(input logic [7:0] b);
    logic [W-1:0] o;
    for (int i = 0; i < NB; i++) o[8*i +: 8] = b;
    return o;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] o;
    for (int i = 0; i < NB; i++) o[8*i +: 8] = 8'($urandom);
    return o;
  endfunction

  // Core model: output is only correct once inputs have been stable LAT cycles
  int         core_age = 0;
  logic [23:0] core_last = '0;
  logic [7:0]  core_good;
  assign core_good = sbox8(sb_si0 ^ sb_si1) ^ sb_r;
  assign sb_bo0 = (core_age >= LAT) ? core_good : ~core_good;
  assign sb_bo1 = (core_age >= LAT) ? sb_r : ~sb_r;

  // Pin monitors: handshake count, core-input stability in HOLD, sb_r change points
  int   hs_total = 0, hold_viol = 0, r_viol = 0;
  logic p_hold = 1'b0, p_rst = 1'b1, p_rhs = 1'b0, p_ohs = 1'b0;
  logic [23:0] p_sb = '0;
  always @(negedge clk) begin
    if ({sb_si0, sb_si1, sb_r} !== core_last) begin
      core_age  = 1;
      core_last = {sb_si0, sb_si1, sb_r};
    end else if (core_age < 1000) begin
      core_age++;
    end
    if (rnd_valid && rnd_ready) hs_total++;
    if (!p_rst && p_hold && ({sb_si0, sb_si1, sb_r} !== p_sb)) hold_viol++;
    if (!p_rst && !p_rhs && !p_ohs && (sb_r !== p_sb[7:0])) r_viol++;
    p_hold = busy && !rnd_ready;
    p_rst  = rst;
    p_rhs  = rnd_valid && rnd_ready;
    p_ohs  = out_valid && out_ready;
    p_sb   = {sb_si0, sb_si1, sb_r};
  end

  // Drives one state through the block; returns at the first cycle out_valid is seen
  task automatic run_state(input logic [W-1:0] s0, input logic [W-1:0] s1,
                           input int unsigned stall, input bit rnd_zero,
                           output int wait_cyc, output int lat,
                           output logic [W-1:0] rv, output bit timeout);
    int unsigned n_hs, stall_left;
    bit offered;
    int k;
    timeout = 1'b0; wait_cyc = 0; lat = 0; rv = '0; n_hs = 0;
    in_s0 = s0; in_s1 = s1; in_valid = 1'b1;
    while (!in_ready && wait_cyc < 200) begin
      @(posedge clk); #1; wait_cyc++;
    end
    if (!in_ready) begin
      in_valid = 1'b0; timeout = 1'b1; return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    stall_left = stall;
    k = 0;
    while (k < 2000) begin
      if (rnd_ready) begin
        if (stall_left > 0) begin
          rnd_valid = 1'b0; stall_left--;
        end else begin
          rnd_valid = 1'b1; rnd = rnd_zero ? 8'h00 : 8'($urandom);
        end
      end else begin
        rnd_valid = 1'b0;
      end
      offered = rnd_valid && rnd_ready;
      @(posedge clk); #1; k++;
      if (offered) begin
        if (n_hs < NB) rv[8*n_hs +: 8] = rnd;
        n_hs++;
        stall_left = stall;
      end
      if (out_valid) break;
    end
    rnd_valid = 1'b0;
    lat = k;
    if (!out_valid) timeout = 1'b1;
  endtask

  logic [W-1:0] z_out0;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({in_ready, out_valid, rnd_ready, busy} !== 4'b1000)
      $display("FAIL reset_hs got=%b want=1000", {in_ready, out_valid, rnd_ready, busy});
    else n_pass++;
    n_total++;
    if ({sb_si0, sb_si1, sb_r} !== 24'h0)
      $display("FAIL reset_sb got=%h want=000000", {sb_si0, sb_si1, sb_r});
    else n_pass++;
    n_total++;
    if ({out_s0, out_s1} !== '0)
      $display("FAIL reset_state got=%h/%h want=0", out_s0, out_s1);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_state();
    int wc, lat, hs0;
    logic [W-1:0] rv;
    bit to;
    hs0 = hs_total;
    run_state('0, '0, 0, 1'b1, wc, lat, rv, to);
    n_total++;
    if (to || lat != 80) $display("FAIL zero_latency got=%0d timeout=%0d want=80", lat, to);
    else n_pass++;
    n_total++;
    if ((out_s0 ^ out_s1) !== rep_byte(8'h65))
      $display("FAIL zero_recombined got=%h want=%h", out_s0 ^ out_s1, rep_byte(8'h65));
    else n_pass++;
    n_total++;
    if (out_s0 !== ref_sh0('0, '0, rv) || out_s1 !== rv)
      $display("FAIL zero_shares got=%h/%h want=%h/%h", out_s0, out_s1, ref_sh0('0, '0, rv), rv);
    else n_pass++;
    z_out0 = out_s0;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n_total++;
    if (hs_total - hs0 != NB) $display("FAIL zero_rnd_count got=%0d want=%0d", hs_total - hs0, NB);
    else n_pass++;
  endtask

  task automatic test_random_masks();
    int wc, lat, hs0;
    logic [W-1:0] rv, m, s0;
    bit to;
    hs0 = hs_total;
    m  = rand_w();
    s0 = m ^ {W{1'b1}};
    run_state(s0, m, 0, 1'b0, wc, lat, rv, to);
    n_total++;
    if (to || (out_s0 ^ out_s1) !== {W{1'b1}})
      $display("FAIL rand_recombined got=%h timeout=%0d want=all ff", out_s0 ^ out_s1, to);
    else n_pass++;
    n_total++;
    if (out_s0 !== ref_sh0(s0, m, rv) || out_s1 !== rv)
      $display("FAIL rand_shares got=%h/%h want=%h/%h", out_s0, out_s1, ref_sh0(s0, m, rv), rv);
    else n_pass++;
    n_total++;
    if (out_s0 === z_out0) $display("FAIL rand_vs_zero got=%h want=different from zero run", out_s0);
    else n_pass++;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n_total++;
    if (hs_total - hs0 != NB) $display("FAIL rand_rnd_count got=%0d want=%0d", hs_total - hs0, NB);
    else n_pass++;
  endtask

  task automatic test_mixed_stall();
    int wc, lat, hv0;
    logic [W-1:0] rv, m, pat, want;
    bit to;
    hv0 = hold_viol;
    for (int i = 0; i < NB; i++) begin
      pat[8*i +: 8]  = (i % 2 == 0) ? 8'h00 : 8'hFF;
      want[8*i +: 8] = (i % 2 == 0) ? 8'h65 : 8'hFF;
    end
    m = rand_w();
    run_state(m ^ pat, m, 3, 1'b0, wc, lat, rv, to);
    n_total++;
    if (to || lat != 128) $display("FAIL stall_latency got=%0d timeout=%0d want=128", lat, to);
    else n_pass++;
    n_total++;
    if ((out_s0 ^ out_s1) !== want)
      $display("FAIL stall_recombined got=%h want=%h", out_s0 ^ out_s1, want);
    else n_pass++;
    n_total++;
    if (out_s0 !== ref_sh0(m ^ pat, m, rv))
      $display("FAIL stall_share0 got=%h want=%h", out_s0, ref_sh0(m ^ pat, m, rv));
    else n_pass++;
    n_total++;
    if (hold_viol != hv0) $display("FAIL stall_sb_hold got=%0d changes want=0", hold_viol - hv0);
    else n_pass++;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int wc, lat;
    logic [W-1:0] rv, s0, s1, o0, o1;
    bit to;
    s0 = rand_w(); s1 = rand_w();
    run_state(s0, s1, 0, 1'b0, wc, lat, rv, to);
    o0 = out_s0; o1 = out_s1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_total++;
      if ({out_valid, in_ready, busy, out_s0, out_s1} !== {3'b100, o0, o1})
        $display("FAIL bp_stable cyc=%0d got=%b/%h/%h want=100/%h/%h",
                 c, {out_valid, in_ready, busy}, out_s0, out_s1, o0, o1);
      else n_pass++;
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n_total++;
    if ({out_valid, in_ready, sb_si0, sb_si1, sb_r} !== {2'b01, 24'h0})
      $display("FAIL bp_release got=%b/%h want=01/000000", {out_valid, in_ready},
               {sb_si0, sb_si1, sb_r});
    else n_pass++;
    s0 = rand_w(); s1 = rand_w();
    run_state(s0, s1, 0, 1'b0, wc, lat, rv, to);
    n_total++;
    if (to || wc != 0 || lat != 80)
      $display("FAIL b2b_accept got=wait%0d/lat%0d/to%0d want=wait0/lat80/to0", wc, lat, to);
    else n_pass++;
    n_total++;
    if (out_s0 !== ref_sh0(s0, s1, rv) || out_s1 !== rv)
      $display("FAIL b2b_shares got=%h/%h want=%h/%h", out_s0, out_s1, ref_sh0(s0, s1, rv), rv);
    else n_pass++;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    int wc, lat, n_hs, k, hs0;
    logic [W-1:0] rv, s0, s1;
    bit to, offered;
    s0 = rand_w(); s1 = rand_w();
    in_s0 = s0; in_s1 = s1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_hs = 0; k = 0;
    while (n_hs < 8 && k < 500) begin
      rnd_valid = rnd_ready; rnd = 8'($urandom);
      offered = rnd_valid && rnd_ready;
      @(posedge clk); #1; k++;
      if (offered) n_hs++;
    end
    rnd_valid = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (n_hs != 8 || !(busy && !rnd_ready))
      $display("FAIL rstmid_reach got=hs%0d busy%0d rdy%0d want=hs8 in HOLD", n_hs, busy, rnd_ready);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++;
    if ({in_ready, out_valid, rnd_ready, busy, sb_si0, sb_si1, sb_r} !== {4'b1000, 24'h0})
      $display("FAIL rstmid_state got=%b/%h want=1000/000000",
               {in_ready, out_valid, rnd_ready, busy}, {sb_si0, sb_si1, sb_r});
    else n_pass++;
    n_total++;
    if ({out_s0, out_s1} !== '0) $display("FAIL rstmid_regs got=%h/%h want=0", out_s0, out_s1);
    else n_pass++;
    hs0 = hs_total;
    s0 = rand_w(); s1 = rand_w();
    run_state(s0, s1, 0, 1'b0, wc, lat, rv, to);
    n_total++;
    if (to || lat != 80 || out_s0 !== ref_sh0(s0, s1, rv) || out_s1 !== rv)
      $display("FAIL rstmid_fresh got=%h/%h lat%0d want=%h/%h lat80",
               out_s0, out_s1, lat, ref_sh0(s0, s1, rv), rv);
    else n_pass++;
    n_total++;
    if (hs_total - hs0 != NB) $display("FAIL rstmid_rnd_count got=%0d want=%0d", hs_total - hs0, NB);
    else n_pass++;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
    in_s0 = '0; in_s1 = '0; rnd = '0;
    test_reset();
    test_zero_state();
    test_random_masks();
    test_mixed_stall();
    test_back_to_back();
    test_reset_mid_hold();
    n_total++;
    if (r_viol != 0) $display("FAIL sb_r_change got=%0d stray changes want=0", r_viol);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
